// File: rtl/rmst_pkg.sv
// Shared definitions for the read-master tile path: FSM encoding, tile sizing
// and byte-per-word helpers used by the controller and the burst reader.
package rmst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RECV  = 3'd3,
    ST_DONE  = 3'd4
  } rmst_state_e;

  localparam int unsigned TILE_LEN       = 64;
  localparam int unsigned RMST_DW        = 32;
  localparam int unsigned BYTES_PER_WORD = RMST_DW / 8;

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/rmst_beat_counter.sv
// Burst beat counter: loaded with the burst length, decremented per returned
// beat, flags the beat that completes the burst (including a beat on the load cycle).
module rmst_beat_counter
  import rmst_pkg::*;
#(
  parameter int unsigned BW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [BW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_last
);

  logic [BW-1:0] r_count;
  logic [BW-1:0] w_base;
  logic [BW-1:0] w_count_nxt;

  // next count: a load and a beat in the same cycle both take effect
  always_comb begin
    w_base      = i_load ? i_load_val : r_count;
    w_count_nxt = w_base;
    o_last      = 1'b0;
    if (i_dec) begin
      w_count_nxt = w_base - BW'(1);
      o_last      = (w_base == BW'(1));
    end else begin
      w_count_nxt = w_base;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/rmst_burst_reader.sv
// Avalon-MM burst read master: splits one tile into bursts of at most
// MAX_BURST words, gated by FIFO room, and pushes every returned word to the FIFO.
module rmst_burst_reader
  import rmst_pkg::*;
#(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_trans_start,
  input  logic [DW-1:0] param_raddr,
  input  logic [AW-1:0] param_iolen,
  output logic          load_trans_done,
  output logic [DW-1:0] avm_address,
  output logic          avm_read,
  output logic [BW-1:0] avm_burstcount,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_readdatavalid,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wdata,
  input  logic          fifo_almost_full,
  output logic          busy
);

  localparam int unsigned    BPW          = bytes_per_word(DW);
  localparam logic [AW-1:0]  MAX_BURST_AW = AW'(MAX_BURST);
  localparam logic [BW-1:0]  MAX_BURST_BW = BW'(MAX_BURST);

  rmst_state_e   r_state;
  logic [DW-1:0] r_cur_addr;
  logic [AW-1:0] r_remaining;
  logic [BW-1:0] r_blen;
  logic [DW-1:0] r_avm_address;
  logic [BW-1:0] r_avm_burstcount;
  logic          r_avm_read;
  logic          r_fifo_wr_en;
  logic [DW-1:0] r_fifo_wdata;
  logic          r_done;
  logic          r_busy;

  rmst_state_e   w_state_nxt;
  logic [DW-1:0] w_cur_addr_nxt;
  logic [AW-1:0] w_remaining_nxt;
  logic [BW-1:0] w_blen_nxt;
  logic [DW-1:0] w_avm_address_nxt;
  logic [BW-1:0] w_avm_burstcount_nxt;
  logic          w_avm_read_nxt;
  logic          w_fifo_wr_en_nxt;
  logic [DW-1:0] w_fifo_wdata_nxt;
  logic          w_done_nxt;
  logic          w_busy_nxt;

  logic          w_accept;
  logic          w_beat;
  logic          w_last;
  logic [BW-1:0] w_blen_calc;
  logic [AW-1:0] w_rem_after;
  logic [DW-1:0] w_addr_after;

  assign w_accept     = (r_state == ST_ISSUE) && r_avm_read && !avm_waitrequest;
  // beats are only meaningful once our request is on the bus; strays are dropped
  assign w_beat       = avm_readdatavalid && ((r_state == ST_RECV) || w_accept);
  assign w_blen_calc  = (r_remaining >= MAX_BURST_AW) ? MAX_BURST_BW : BW'(r_remaining);
  assign w_rem_after  = r_remaining - AW'(r_blen);
  assign w_addr_after = r_cur_addr + (DW'(r_blen) * DW'(BPW));

  rmst_beat_counter #(
    .BW (BW)
  ) u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (r_blen),
    .i_dec      (w_beat),
    .o_last     (w_last)
  );

  // next-state and next-output computation
  always_comb begin
    w_state_nxt          = r_state;
    w_cur_addr_nxt       = r_cur_addr;
    w_remaining_nxt      = r_remaining;
    w_blen_nxt           = r_blen;
    w_avm_address_nxt    = r_avm_address;
    w_avm_burstcount_nxt = r_avm_burstcount;
    w_avm_read_nxt       = r_avm_read;
    w_fifo_wr_en_nxt     = 1'b0;
    w_fifo_wdata_nxt     = r_fifo_wdata;
    w_done_nxt           = 1'b0;
    w_busy_nxt           = r_busy;

    if (w_beat) begin
      w_fifo_wr_en_nxt = 1'b1;
      w_fifo_wdata_nxt = avm_readdata;
    end else begin
      w_fifo_wr_en_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (load_trans_start) begin
          w_cur_addr_nxt  = param_raddr;
          w_remaining_nxt = param_iolen;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = (param_iolen != AW'(0)) ? ST_CHECK : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!fifo_almost_full) begin
          w_blen_nxt           = w_blen_calc;
          w_avm_address_nxt    = r_cur_addr;
          w_avm_burstcount_nxt = w_blen_calc;
          w_avm_read_nxt       = 1'b1;
          w_state_nxt          = ST_ISSUE;
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          w_avm_read_nxt = 1'b0;
          w_state_nxt    = ST_RECV;
          if (w_last) begin
            w_remaining_nxt = w_rem_after;
            w_cur_addr_nxt  = w_addr_after;
            w_state_nxt     = (w_rem_after == AW'(0)) ? ST_DONE : ST_CHECK;
          end else begin
            w_state_nxt = ST_RECV;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_RECV: begin
        if (w_last) begin
          w_remaining_nxt = w_rem_after;
          w_cur_addr_nxt  = w_addr_after;
          w_state_nxt     = (w_rem_after == AW'(0)) ? ST_DONE : ST_CHECK;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_avm_read_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_cur_addr       <= '0;
      r_remaining      <= '0;
      r_blen           <= '0;
      r_avm_address    <= '0;
      r_avm_burstcount <= '0;
      r_avm_read       <= 1'b0;
      r_fifo_wr_en     <= 1'b0;
      r_fifo_wdata     <= '0;
      r_done           <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cur_addr       <= w_cur_addr_nxt;
      r_remaining      <= w_remaining_nxt;
      r_blen           <= w_blen_nxt;
      r_avm_address    <= w_avm_address_nxt;
      r_avm_burstcount <= w_avm_burstcount_nxt;
      r_avm_read       <= w_avm_read_nxt;
      r_fifo_wr_en     <= w_fifo_wr_en_nxt;
      r_fifo_wdata     <= w_fifo_wdata_nxt;
      r_done           <= w_done_nxt;
      r_busy           <= w_busy_nxt;
    end
  end

  assign load_trans_done = r_done;
  assign avm_address     = r_avm_address;
  assign avm_read        = r_avm_read;
  assign avm_burstcount  = r_avm_burstcount;
  assign fifo_wr_en      = r_fifo_wr_en;
  assign fifo_wdata      = r_fifo_wdata;
  assign busy            = r_busy;

endmodule

// File: tb/tb_rmst_burst_reader.sv
// Directed self-checking bench for rmst_burst_reader: a scripted Avalon slave
// answers each burst while a monitor logs accepted requests, FIFO writes and done pulses.
module tb_rmst_burst_reader;

  logic        clk;
  logic        rst;
  logic        load_trans_start;
  logic [31:0] param_raddr;
  logic [11:0] param_iolen;
  logic        load_trans_done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic        fifo_almost_full;
  logic        busy;

  int checks;
  int failures;
  logic [31:0] data_next;
  logic        mon_clr;

  int          cyc;
  int          wr_cnt;
  int          done_cnt;
  int          acc_cnt;
  int          read_cycles;
  int          last_wr_cyc;
  int          done_cyc;
  logic [31:0] wr_log  [64];
  logic [31:0] acc_addr[8];
  logic [4:0]  acc_bc  [8];

  rmst_burst_reader dut (
    .clk               (clk),
    .rst               (rst),
    .load_trans_start  (load_trans_start),
    .param_raddr       (param_raddr),
    .param_iolen       (param_iolen),
    .load_trans_done   (load_trans_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_wdata        (fifo_wdata),
    .fifo_almost_full  (fifo_almost_full),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt      <= 0;
      done_cnt    <= 0;
      acc_cnt     <= 0;
      read_cycles <= 0;
      last_wr_cyc <= -10;
      done_cyc    <= -20;
    end else begin
      if (fifo_wr_en) begin
        if (wr_cnt < 64) wr_log[wr_cnt] <= fifo_wdata;
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc;
      end
      if (load_trans_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (avm_read) read_cycles <= read_cycles + 1;
      if (avm_read && !avm_waitrequest) begin
        if (acc_cnt < 8) begin
          acc_addr[acc_cnt] <= avm_address;
          acc_bc[acc_cnt]   <= avm_burstcount;
        end
        acc_cnt <= acc_cnt + 1;
      end
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic start_tile(input logic [31:0] addr, input logic [11:0] len);
    param_raddr      = addr;
    param_iolen      = len;
    load_trans_start = 1'b1;
    tick();
    load_trans_start = 1'b0;
  endtask

  task automatic wait_read();
    int k;
    k = 0;
    while (avm_read !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("read_seen", {63'd0, avm_read}, 64'd1);
  endtask

  // one burst: optional waitrequest stall, then beats with a gap before every gap-th beat
  task automatic serve_burst(input int wait_cycles, input int gap);
    logic [31:0] a0;
    logic [4:0]  b0;
    wait_read();
    a0 = avm_address;
    b0 = avm_burstcount;
    avm_waitrequest = (wait_cycles > 0);
    for (int w = 0; w < wait_cycles; w++) begin
      tick();
      check("hold_read", {63'd0, avm_read}, 64'd1);
      check("hold_addr", {32'd0, avm_address}, {32'd0, a0});
      check("hold_bc", {59'd0, avm_burstcount}, {59'd0, b0});
    end
    avm_waitrequest = 1'b0;
    tick();
    check("read_drop", {63'd0, avm_read}, 64'd0);
    for (int b = 0; b < int'(b0); b++) begin
      if (gap > 0 && (b % gap) == gap - 1) begin
        avm_readdatavalid = 1'b0;
        tick();
      end
      avm_readdatavalid = 1'b1;
      avm_readdata      = data_next;
      data_next         = data_next + 32'd1;
      tick();
    end
    avm_readdatavalid = 1'b0;
  endtask

  task automatic finish_tile(input int n, input logic [31:0] base);
    tick();
    tick();
    tick();
    check("wr_count", 64'(wr_cnt), 64'(n));
    for (int i = 0; i < n && i < 64; i++)
      check("wr_data", {32'd0, wr_log[i]}, {32'd0, base + 32'(i)});
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("busy_clear", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_acc(input int idx, input logic [31:0] addr, input logic [4:0] bc);
    check("acc_addr", {32'd0, acc_addr[idx]}, {32'd0, addr});
    check("acc_bc", {59'd0, acc_bc[idx]}, {59'd0, bc});
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    cyc               = 0;
    data_next         = 32'd0;
    mon_clr           = 1'b1;
    rst               = 1'b0;
    load_trans_start  = 1'b0;
    param_raddr       = 32'd0;
    param_iolen       = 12'd0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'd0;
    avm_readdatavalid = 1'b0;
    fifo_almost_full  = 1'b0;
    tick();
    tick();
    tick();
    check("rst_read", {63'd0, avm_read}, 64'd0);
    check("rst_addr", {32'd0, avm_address}, 64'd0);
    check("rst_bc", {59'd0, avm_burstcount}, 64'd0);
    check("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    check("rst_wdata", {32'd0, fifo_wdata}, 64'd0);
    check("rst_done", {63'd0, load_trans_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    mon_clear();

    // 40 words at 0x1000, no stalls: 16 + 16 + 8
    data_next = 32'h100;
    start_tile(32'h1000, 12'd40);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_read_t1", {63'd0, avm_read}, 64'd0);
    tick();
    check("t1_read_t2", {63'd0, avm_read}, 64'd1);
    serve_burst(0, 0);
    serve_burst(0, 0);
    serve_burst(0, 0);
    finish_tile(40, 32'h100);
    check("t1_acc_cnt", 64'(acc_cnt), 64'd3);
    check_acc(0, 32'h1000, 5'd16);
    check_acc(1, 32'h1040, 5'd16);
    check_acc(2, 32'h1080, 5'd8);
    mon_clear();

    // 16 words with a 7-cycle waitrequest stall
    data_next = 32'h200;
    start_tile(32'h0800, 12'd16);
    serve_burst(7, 0);
    finish_tile(16, 32'h200);
    check("t2_acc_cnt", 64'(acc_cnt), 64'd1);
    check("t2_read_cycles", 64'(read_cycles), 64'd8);
    check_acc(0, 32'h0800, 5'd16);
    mon_clear();

    // 32 words, FIFO almost full for 20 cycles before the second burst
    data_next = 32'h300;
    start_tile(32'h2000, 12'd32);
    serve_burst(0, 0);
    fifo_almost_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_no_read", {63'd0, avm_read}, 64'd0);
    end
    fifo_almost_full = 1'b0;
    serve_burst(0, 0);
    finish_tile(32, 32'h300);
    check("t3_acc_cnt", 64'(acc_cnt), 64'd2);
    check_acc(1, 32'h2040, 5'd16);
    mon_clear();

    // zero-length tile; a second start while busy is ignored
    start_tile(32'h5000, 12'd0);
    check("t4_done_early", {63'd0, load_trans_done}, 64'd0);
    check("t4_busy", {63'd0, busy}, 64'd1);
    param_iolen      = 12'd5;
    load_trans_start = 1'b1;
    tick();
    load_trans_start = 1'b0;
    check("t4_done", {63'd0, load_trans_done}, 64'd1);
    check("t4_busy_drop", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t4_busy_idle", {63'd0, busy}, 64'd0);
    check("t4_acc_cnt", 64'(acc_cnt), 64'd0);
    check("t4_read_cycles", 64'(read_cycles), 64'd0);
    check("t4_wr_cnt", 64'(wr_cnt), 64'd0);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    mon_clear();

    // 20 words across the address wrap, with gaps between beats
    data_next = 32'h400;
    start_tile(32'hFFFF_FFF0, 12'd20);
    serve_burst(0, 3);
    serve_burst(0, 2);
    finish_tile(20, 32'h400);
    check("t5_acc_cnt", 64'(acc_cnt), 64'd2);
    check_acc(0, 32'hFFFF_FFF0, 5'd16);
    check_acc(1, 32'h0000_0030, 5'd4);
    mon_clear();

    // reset in the middle of a burst, stray beats afterwards, then a clean tile
    data_next = 32'h600;
    start_tile(32'h3000, 12'd16);
    wait_read();
    tick();
    for (int i = 0; i < 3; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = data_next;
      data_next         = data_next + 32'd1;
      tick();
    end
    rst = 1'b0;
    #1;
    check("t6_rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    check("t6_rst_wdata", {32'd0, fifo_wdata}, 64'd0);
    check("t6_rst_read", {63'd0, avm_read}, 64'd0);
    check("t6_rst_addr", {32'd0, avm_address}, 64'd0);
    check("t6_rst_bc", {59'd0, avm_burstcount}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_done", {63'd0, load_trans_done}, 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stray_wr", {63'd0, fifo_wr_en}, 64'd0);
    end
    avm_readdatavalid = 1'b0;
    tick();
    check("t6_stray_wr_last", {63'd0, fifo_wr_en}, 64'd0);
    mon_clear();
    data_next = 32'h700;
    start_tile(32'h4000, 12'd4);
    serve_burst(0, 0);
    finish_tile(4, 32'h700);
    check("t6_acc_cnt", 64'(acc_cnt), 64'd1);
    check_acc(0, 32'h4000, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
